i2c_cfg_sequencer: RTL and testbench
====================================

Name: i2c_cfg_sequencer

Overview:
Parametrised successor to the fixed-table audio/video auto-initialiser. It walks an external configuration table of arbitrary depth and drives the existing byte-level I2C transfer engine using the same handshake. It adds per-entry opcodes (write, delay, end), automatic retry on NACK, a re-triggerable start and error reporting. It sits between the board-level configuration ROM (registered, block RAM) and the I2C engine serving the audio codec and video decoder.

Parameters:
ADDR_W, 6, table index width; the table holds up to 2**ADDR_W entries.
NUM_ENTRIES, 50, hard stop index; the sequence ends at this index even if no END opcode has been read.
RETRY_MAX, 3, extra attempts per write entry after a NACK (0 = no retry).
DELAY_SHIFT, 4, delay entry waits data[15:0] << DELAY_SHIFT clock cycles.
AUTO_START, 1, 1 = run automatically after reset release; 0 = wait for start.

Ports:
clk  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse to (re)run the table from index 0
clear_error  input  1  clears init_error
cfg_addr  output  ADDR_W  table index; data is valid one cycle later
cfg_data  input  26  entry {op[1:0], dev_addr[7:0], reg[7:0], val[7:0]}
ack  input  1  from engine; 1 = NACK on the last byte
transfer_complete  input  1  from engine; byte or stop finished
data_out  output  8  byte to send
transfer_data  output  1  byte request
send_start_bit  output  1  prefix the current byte with START
send_stop_bit  output  1  issue STOP
busy  output  1  sequence in progress
init_complete  output  1  sequence finished (held)
init_error  output  1  sticky: some entry failed after all retries
cur_index  output  ADDR_W  index of the entry being processed

Behaviour:
- Reset: all outputs 0, state IDLE, index 0, retry count 0. On reset_n release with AUTO_START=1, the block enters FETCH on the first clk edge.
- Opcodes:
  - 01: WRITE (dev_addr, reg, val).
  - 10: DELAY of {reg,val} << DELAY_SHIFT cycles. A zero count waits 0 extra cycles.
  - 00: END.
  - 11: reserved; skip.
- States:
  - IDLE: start -> FETCH.
  - FETCH: drive cfg_addr = index; next cycle -> DECODE.
  - DECODE: index == NUM_ENTRIES or op==00 -> DONE; op==10 -> DELAY; op==11 -> NEXT; op==01 -> BYTE1.
  - BYTE1/BYTE2/BYTE3: data_out = dev_addr, reg and val respectively. send_start_bit=1 only in BYTE1. transfer_data=1. A byte is accepted when transfer_complete & transfer_data. On acceptance transfer_data and send_start_bit clear the following cycle and the state advances. If ack=1 at acceptance, the nack flag is set.
  - STOPWAIT: wait for transfer_complete=0 -> STOP.
  - STOP: send_stop_bit=1 until transfer_complete=1, then clear -> RESOLVE.
  - RESOLVE:
    - nack & retry<RETRY_MAX: retry++, clear nack -> BYTE1 (same entry).
    - nack & retry==RETRY_MAX: set init_error -> NEXT.
    - otherwise -> NEXT.
  - DELAY: load counter; count down to 0 -> NEXT.
  - NEXT: index+1, retry=0, nack=0 -> FETCH.
  - DONE: init_complete=1; start -> index 0, init_complete=0 -> FETCH.
- busy=1 in every state except IDLE and DONE.
- start while busy: ignored.
- The index never wraps past 2**ADDR_W-1. When NUM_ENTRIES == 2**ADDR_W, DONE is reached after the last entry, on the wrap to 0, which is detected as terminal.
- clear_error has priority over a same-cycle error set.
- reset_n asserted mid-transfer: immediate return to reset values. The engine is responsible for bus recovery.

Optional Feature:
Macro I2C_CFG_ERR_CAPTURE_EN.
- Defined: adds outputs err_index[ADDR_W-1:0] and err_count[7:0].
  - err_index holds the index of the first entry that exhausted its retries.
  - err_count counts failed entries and saturates at 255.
  - clear_error clears both.
- Undefined: these ports and their registers do not exist; init_error alone reports failure.

Test Plan:
- Table of 3 WRITEs then END; engine model always ACKs -> exactly 9 byte transfers and 3 stops. send_start_bit is high only with bytes 0x34, 0x34, 0x34. init_complete=1 with init_error=0 and cur_index=3.
- Entry 1 NACKs twice, then ACKs, RETRY_MAX=3 -> entry 1 is sent 3 times, init_error=0, sequence completes.
- Entry 0 always NACKs, RETRY_MAX=3 -> 4 attempts, init_error=1, entry 1 is still sent. With the macro: err_index=0, err_count=1.
- DELAY entry {reg,val}=0x0005, DELAY_SHIFT=4 -> 80 cycles (±2 for FETCH/NEXT overhead) with no transfer_data between the surrounding writes.
- No END opcode, NUM_ENTRIES=4 -> DONE after index 3. A start pulse in DONE re-runs all 4 entries. A start pulse mid-run is ignored.
- reset_n pulsed low during BYTE2 -> all outputs 0 asynchronously. With AUTO_START=1 the sequence restarts at index 0.

Source files
------------

// File: rtl/i2c_cfg_sequencer.sv
// Walks an external configuration table (write / delay / end opcodes) and drives a
// byte-level I2C engine with NACK retry. Macro I2C_CFG_ERR_CAPTURE_EN adds err_index/err_count.
module i2c_cfg_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int NUM_ENTRIES = 50,
  parameter int RETRY_MAX   = 3,
  parameter int DELAY_SHIFT = 4,
  parameter int AUTO_START  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              clear_error,
  output logic [ADDR_W-1:0] cfg_addr,
  input  logic [25:0]       cfg_data,
  input  logic              ack,
  input  logic              transfer_complete,
  output logic [7:0]        data_out,
  output logic              transfer_data,
  output logic              send_start_bit,
  output logic              send_stop_bit,
  output logic              busy,
  output logic              init_complete,
  output logic              init_error,
`ifdef I2C_CFG_ERR_CAPTURE_EN
  output logic [ADDR_W-1:0] err_index,
  output logic [7:0]        err_count,
`endif
  output logic [ADDR_W-1:0] cur_index
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] FETCH    = 4'd1;
  localparam logic [3:0] DECODE   = 4'd2;
  localparam logic [3:0] BYTE1    = 4'd3;
  localparam logic [3:0] BYTE2    = 4'd4;
  localparam logic [3:0] BYTE3    = 4'd5;
  localparam logic [3:0] STOPWAIT = 4'd6;
  localparam logic [3:0] STOP     = 4'd7;
  localparam logic [3:0] RESOLVE  = 4'd8;
  localparam logic [3:0] DELAY    = 4'd9;
  localparam logic [3:0] NEXT     = 4'd10;
  localparam logic [3:0] DONE     = 4'd11;

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RETRY_LIM = RETRY_MAX[RW-1:0];
  localparam int CW = 16 + DELAY_SHIFT;
  localparam int END_INT = (NUM_ENTRIES > (2 ** ADDR_W)) ? (2 ** ADDR_W) : NUM_ENTRIES;
  localparam logic [ADDR_W:0] END_IDX = END_INT[ADDR_W:0];

  logic [3:0]        state;
  logic [ADDR_W-1:0] index;
  logic              at_end;
  logic              auto_go;
  logic              nack;
  logic [RW-1:0]     retry;
  logic [CW-1:0]     delay_cnt;
  logic [23:0]       entry;
  logic              is_end;
  logic              err_set;

  assign cfg_addr      = index;
  assign cur_index     = index;
  assign busy          = (state != IDLE) && (state != DONE);
  assign init_complete = (state == DONE);

  // at_end marks the wrap past the last index, which cannot be compared against END_IDX
  assign is_end  = at_end || ({1'b0, index} == END_IDX) || (cfg_data[25:24] == 2'b00);
  assign err_set = (state == RESOLVE) && nack && (retry == RETRY_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      index          <= '0;
      at_end         <= 1'b0;
      auto_go        <= (AUTO_START != 0);
      nack           <= 1'b0;
      retry          <= '0;
      delay_cnt      <= '0;
      entry          <= '0;
      data_out       <= 8'h00;
      transfer_data  <= 1'b0;
      send_start_bit <= 1'b0;
      send_stop_bit  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start || auto_go) begin
            auto_go <= 1'b0;
            state   <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          entry <= cfg_data[23:0];
          if (is_end) begin
            state <= DONE;
          end else begin
            case (cfg_data[25:24])
              2'b10: begin
                delay_cnt <= CW'(cfg_data[15:0]) << DELAY_SHIFT;
                state     <= DELAY;
              end
              2'b11:   state <= NEXT;
              default: state <= BYTE1;
            endcase
          end
        end
        BYTE1, BYTE2, BYTE3: begin
          // a new request is raised only once the engine has dropped its previous completion
          if (transfer_data && transfer_complete) begin
            transfer_data  <= 1'b0;
            send_start_bit <= 1'b0;
            if (ack) nack <= 1'b1;
            state <= (state == BYTE1) ? BYTE2 : (state == BYTE2) ? BYTE3 : STOPWAIT;
          end else if (!transfer_data && !transfer_complete) begin
            transfer_data  <= 1'b1;
            send_start_bit <= (state == BYTE1);
            data_out       <= (state == BYTE1) ? entry[23:16] :
                              (state == BYTE2) ? entry[15:8] : entry[7:0];
          end
        end
        STOPWAIT: if (!transfer_complete) state <= STOP;
        STOP: begin
          if (send_stop_bit && transfer_complete) begin
            send_stop_bit <= 1'b0;
            state         <= RESOLVE;
          end else begin
            send_stop_bit <= 1'b1;
          end
        end
        RESOLVE: begin
          if (nack && (retry != RETRY_LIM)) begin
            retry <= retry + 1'b1;
            nack  <= 1'b0;
            state <= BYTE1;
          end else begin
            state <= NEXT;
          end
        end
        DELAY: begin
          if (delay_cnt == '0) state <= NEXT;
          else delay_cnt <= delay_cnt - 1'b1;
        end
        NEXT: begin
          index  <= index + 1'b1;
          at_end <= &index;
          retry  <= '0;
          nack   <= 1'b0;
          state  <= FETCH;
        end
        DONE: begin
          if (start) begin
            index  <= '0;
            at_end <= 1'b0;
            state  <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) init_error <= 1'b0;
    else if (clear_error) init_error <= 1'b0;
    else if (err_set) init_error <= 1'b1;
  end

`ifdef I2C_CFG_ERR_CAPTURE_EN
  // err_count of zero doubles as "no failure captured yet" since it saturates at 255
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_index <= '0;
      err_count <= 8'h00;
    end else if (clear_error) begin
      err_index <= '0;
      err_count <= 8'h00;
    end else if (err_set) begin
      if (err_count == 8'h00) err_index <= index;
      if (err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Self-checking bench for i2c_cfg_sequencer: table ROM + I2C engine models and a
// table-walking reference model. Checks err_index/err_count when I2C_CFG_ERR_CAPTURE_EN is set.
module tb_i2c_cfg_sequencer;

  localparam int ADDR_W      = 3;
  localparam int NUM         = 8;
  localparam int RETRY_MAX   = 3;
  localparam int DELAY_SHIFT = 4;
  localparam int LIMIT       = 6000;

  logic clk = 1'b0;
  logic reset_n, start, clear_error, ack, transfer_complete;
  logic [ADDR_W-1:0] cfg_addr, cur_index;
  logic [25:0] cfg_data;
  logic [7:0] data_out;
  logic transfer_data, send_start_bit, send_stop_bit, busy, init_complete, init_error;
`ifdef I2C_CFG_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] err_index;
  logic [7:0] err_count;
`endif

  logic [25:0] tbl [NUM];
  int lat_max = 2;
  int nack_limit = 0;
  int nack_used = 0;
  int stop_count = 0;
  int eng_wait, byte_pos;
  logic [7:0] nack_reg = 8'hA5;
  logic [7:0] eng_reg;
  logic [8:0] byte_log[$];
  int rise_log[$];
  int cycle = 0;
  logic prev_sb = 1'b0;

  int passed = 0;
  int total = 0;
  int log_base, stop_base, rise_base;
  logic [8:0] exp_bytes[$];
  int exp_stops, exp_err_idx, exp_err_cnt, exp_end;
  logic exp_err;

  i2c_cfg_sequencer #(
    .ADDR_W(ADDR_W), .NUM_ENTRIES(NUM), .RETRY_MAX(RETRY_MAX),
    .DELAY_SHIFT(DELAY_SHIFT), .AUTO_START(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear_error(clear_error),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .ack(ack),
    .transfer_complete(transfer_complete), .data_out(data_out),
    .transfer_data(transfer_data), .send_start_bit(send_start_bit),
    .send_stop_bit(send_stop_bit), .busy(busy), .init_complete(init_complete),
    .init_error(init_error),
`ifdef I2C_CFG_ERR_CAPTURE_EN
    .err_index(err_index), .err_count(err_count),
`endif
    .cur_index(cur_index)
  );

  always #5 clk = ~clk;

  // registered configuration ROM
  always @(posedge clk) cfg_data <= tbl[cfg_addr];

  // I2C engine: random latency, one-cycle completion pulse, NACKs the value byte of matching entries
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      transfer_complete <= 1'b0;
      ack <= 1'b0;
      eng_wait <= 0;
      byte_pos <= 0;
      eng_reg <= 8'h00;
    end else begin
      transfer_complete <= 1'b0;
      ack <= 1'b0;
      if (!transfer_complete && (transfer_data || send_stop_bit)) begin
        if (eng_wait != 0) begin
          eng_wait <= eng_wait - 1;
        end else begin
          transfer_complete <= 1'b1;
          eng_wait <= int'($urandom_range(lat_max, 0));
          if (transfer_data) begin
            byte_log.push_back({send_start_bit, data_out});
            byte_pos <= send_start_bit ? 1 : byte_pos + 1;
            if (!send_start_bit && byte_pos == 1) eng_reg <= data_out;
            if (!send_start_bit && byte_pos == 2 && eng_reg == nack_reg && nack_used < nack_limit) begin
              ack <= 1'b1;
              nack_used <= nack_used + 1;
            end
          end else begin
            stop_count <= stop_count + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (transfer_data && send_start_bit && !prev_sb) rise_log.push_back(cycle);
    prev_sb <= transfer_data && send_start_bit;
  end

  // Reference: walk the table by its opcode rules, retrying NACKed writes up to RETRY_MAX times
  function automatic void run_model(input int nack_n);
    int budget;
    logic nacked;
    budget = nack_n;
    exp_bytes.delete();
    exp_stops = 0; exp_err = 1'b0; exp_err_idx = 0; exp_err_cnt = 0; exp_end = 0;
    for (int i = 0; i <= NUM; i++) begin
      if (i == NUM) begin exp_end = i % (2 ** ADDR_W); break; end
      if (tbl[i][25:24] == 2'b00) begin exp_end = i; break; end
      if (tbl[i][25:24] == 2'b01) begin
        for (int a = 0; a <= RETRY_MAX; a++) begin
          exp_bytes.push_back({1'b1, tbl[i][23:16]});
          exp_bytes.push_back({1'b0, tbl[i][15:8]});
          exp_bytes.push_back({1'b0, tbl[i][7:0]});
          exp_stops++;
          nacked = (tbl[i][15:8] == nack_reg) && (budget > 0);
          if (nacked) budget--;
          if (!nacked) break;
          if (a == RETRY_MAX) begin
            if (exp_err_cnt == 0) exp_err_idx = i;
            if (exp_err_cnt < 255) exp_err_cnt++;
            exp_err = 1'b1;
          end
        end
      end
    end
  endfunction

  function automatic logic [25:0] wr(input logic [7:0] dev, input logic [7:0] rg);
    return {2'b01, dev, rg, 8'($urandom)};
  endfunction

  task automatic load_basic_table;
    for (int i = 0; i < NUM; i++) tbl[i] = 26'h0;
    for (int i = 0; i < 3; i++) tbl[i] = wr(8'h34, 8'($urandom_range(0, 127)));
  endtask

  task automatic launch;
    @(negedge clk); clear_error = 1'b1;
    @(negedge clk); clear_error = 1'b0;
    log_base = byte_log.size(); stop_base = stop_count; rise_base = rise_log.size();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    int n;
    n = 0;
    while (!init_complete && n < LIMIT) begin @(negedge clk); n++; end
    timed_out = !init_complete;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; clear_error = 1'b0;
    nack_limit = nack_used;
    load_basic_table();
    repeat (2) @(negedge clk);
    total++;
    if ({busy, init_complete, init_error, transfer_data, send_start_bit, send_stop_bit} !== 6'b0)
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {busy, init_complete, init_error, transfer_data, send_start_bit, send_stop_bit});
    else passed++;
    total++;
    if ({data_out, cur_index, cfg_addr} !== '0)
      $display("[TB] FAIL reset_data: got %h/%h/%h expected 0", data_out, cur_index, cfg_addr);
    else passed++;
    log_base = byte_log.size(); stop_base = stop_count;
    run_model(0);
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("[TB] FAIL auto_start_busy: got %b expected 1", busy);
    else passed++;
  endtask

  task automatic test_basic_writes;
    bit to;
    wait_done(to);
    total++;
    if (to) $display("[TB] FAIL basic_timeout: got no done expected done"); else passed++;
    total++;
    if (byte_log.size() - log_base !== 9)
      $display("[TB] FAIL basic_byte_count: got %0d expected 9", byte_log.size() - log_base);
    else passed++;
    for (int k = 0; k < exp_bytes.size() && log_base + k < byte_log.size(); k++) begin
      total++;
      if (byte_log[log_base + k] !== exp_bytes[k])
        $display("[TB] FAIL basic_byte%0d: got %h expected %h", k, byte_log[log_base + k], exp_bytes[k]);
      else passed++;
    end
    total++;
    if (stop_count - stop_base !== 3)
      $display("[TB] FAIL basic_stops: got %0d expected 3", stop_count - stop_base);
    else passed++;
    total++;
    if ({init_complete, init_error, busy, cur_index} !== {1'b1, 1'b0, 1'b0, 3'd3})
      $display("[TB] FAIL basic_final: got %b%b%b idx %0d expected 100 idx 3",
               init_complete, init_error, busy, cur_index);
    else passed++;
  endtask

  task automatic test_retry_recovers;
    bit to;
    load_basic_table();
    tbl[1] = wr(8'h34, 8'hA5);
    nack_limit = nack_used + 2;
    run_model(2);
    launch();
    wait_done(to);
    total++;
    if (to) $display("[TB] FAIL retry_ok_timeout: got no done expected done"); else passed++;
    total++;
    if (byte_log.size() - log_base !== 15)
      $display("[TB] FAIL retry_ok_count: got %0d expected 15", byte_log.size() - log_base);
    else passed++;
    for (int k = 0; k < exp_bytes.size() && log_base + k < byte_log.size(); k++) begin
      total++;
      if (byte_log[log_base + k] !== exp_bytes[k])
        $display("[TB] FAIL retry_ok_byte%0d: got %h expected %h", k, byte_log[log_base + k], exp_bytes[k]);
      else passed++;
    end
    total++;
    if ({init_error, 8'(stop_count - stop_base)} !== {1'b0, 8'd5})
      $display("[TB] FAIL retry_ok_err_stops: got %b/%0d expected 0/5", init_error, stop_count - stop_base);
    else passed++;
  endtask

  task automatic test_retry_exhausted;
    bit to;
    for (int i = 0; i < NUM; i++) tbl[i] = 26'h0;
    tbl[0] = wr(8'h1A, 8'hA5);
    tbl[1] = wr(8'h1A, 8'($urandom_range(0, 127)));
    nack_limit = nack_used + 100;
    run_model(100);
    launch();
    wait_done(to);
    total++;
    if (to) $display("[TB] FAIL exhaust_timeout: got no done expected done"); else passed++;
    total++;
    if (byte_log.size() - log_base !== exp_bytes.size())
      $display("[TB] FAIL exhaust_count: got %0d expected %0d", byte_log.size() - log_base, exp_bytes.size());
    else passed++;
    for (int k = 0; k < exp_bytes.size() && log_base + k < byte_log.size(); k++) begin
      total++;
      if (byte_log[log_base + k] !== exp_bytes[k])
        $display("[TB] FAIL exhaust_byte%0d: got %h expected %h", k, byte_log[log_base + k], exp_bytes[k]);
      else passed++;
    end
    total++;
    if (init_error !== exp_err)
      $display("[TB] FAIL exhaust_error: got %b expected %b (entry %0d)", init_error, exp_err, exp_err_idx);
    else passed++;
`ifdef I2C_CFG_ERR_CAPTURE_EN
    total++;
    if ({err_index, err_count} !== {ADDR_W'(exp_err_idx), 8'(exp_err_cnt)})
      $display("[TB] FAIL exhaust_capture: got %0d/%0d expected %0d/%0d",
               err_index, err_count, exp_err_idx, exp_err_cnt);
    else passed++;
`endif
    clear_error = 1'b1;
    @(negedge clk); clear_error = 1'b0;
    total++;
    if (init_error !== 1'b0) $display("[TB] FAIL clear_error: got %b expected 0", init_error);
    else passed++;
`ifdef I2C_CFG_ERR_CAPTURE_EN
    total++;
    if (err_count !== 8'd0) $display("[TB] FAIL clear_count: got %0d expected 0", err_count);
    else passed++;
`endif
  endtask

  task automatic test_delay;
    bit to;
    int d;
    lat_max = 0;
    nack_limit = nack_used;
    for (int i = 0; i < NUM; i++) tbl[i] = 26'h0;
    tbl[0] = wr(8'h22, 8'h01);
    tbl[1] = {2'b10, 8'h00, 16'h0005};
    tbl[2] = wr(8'h22, 8'h02);
    tbl[3] = {2'b10, 8'h00, 16'h0000};
    tbl[4] = wr(8'h22, 8'h03);
    run_model(0);
    launch();
    wait_done(to);
    total++;
    if (to) $display("[TB] FAIL delay_timeout: got no done expected done"); else passed++;
    total++;
    if (byte_log.size() - log_base !== 9)
      $display("[TB] FAIL delay_byte_count: got %0d expected 9", byte_log.size() - log_base);
    else passed++;
    d = -1000;
    if (rise_log.size() >= rise_base + 3)
      d = (rise_log[rise_base + 1] - rise_log[rise_base]) - (rise_log[rise_base + 2] - rise_log[rise_base + 1]);
    total++;
    if (d < 78 || d > 82) $display("[TB] FAIL delay_cycles: got %0d expected 80 +/-2", d);
    else passed++;
    lat_max = 3;
  endtask

  task automatic test_hard_stop;
    bit to;
    int n;
    for (int i = 0; i < NUM; i++) tbl[i] = wr(8'($urandom), 8'($urandom_range(0, 127)));
    tbl[5] = {2'b11, 24'($urandom)};
    nack_limit = nack_used;
    run_model(0);
    launch();
    n = 0;
    while (byte_log.size() < log_base + 4 && n < LIMIT) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(to);
    total++;
    if (to) $display("[TB] FAIL hard_stop_timeout: got no done expected done"); else passed++;
    total++;
    if (byte_log.size() - log_base !== 21)
      $display("[TB] FAIL hard_stop_count: got %0d expected 21", byte_log.size() - log_base);
    else passed++;
    total++;
    if ({cur_index, 8'(stop_count - stop_base)} !== {ADDR_W'(exp_end), 8'd7})
      $display("[TB] FAIL hard_stop_index_stops: got %0d/%0d expected %0d/7",
               cur_index, stop_count - stop_base, exp_end);
    else passed++;
    launch();
    total++;
    if ({busy, init_complete} !== 2'b10)
      $display("[TB] FAIL rerun_start: got %b%b expected 10", busy, init_complete);
    else passed++;
    wait_done(to);
    total++;
    if (to) $display("[TB] FAIL rerun_timeout: got no done expected done"); else passed++;
    for (int k = 0; k < exp_bytes.size(); k++) begin
      total++;
      if (log_base + k >= byte_log.size() || byte_log[log_base + k] !== exp_bytes[k])
        $display("[TB] FAIL rerun_byte%0d: got %h expected %h", k,
                 (log_base + k < byte_log.size()) ? byte_log[log_base + k] : 9'h1FF, exp_bytes[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_transfer;
    bit to;
    int n;
    load_basic_table();
    nack_limit = nack_used;
    launch();
    n = 0;
    while (!(byte_log.size() == log_base + 1 && transfer_data) && n < LIMIT) begin @(negedge clk); n++; end
    total++;
    if (n >= LIMIT) $display("[TB] FAIL byte2_reached: got timeout expected BYTE2"); else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({busy, init_complete, transfer_data, send_start_bit, send_stop_bit, data_out, cur_index} !== '0)
      $display("[TB] FAIL async_reset: got %b%b%b%b%b %h %0d expected all 0",
               busy, init_complete, transfer_data, send_start_bit, send_stop_bit, data_out, cur_index);
    else passed++;
    @(negedge clk);
    log_base = byte_log.size(); stop_base = stop_count;
    run_model(0);
    reset_n = 1'b1;
    wait_done(to);
    total++;
    if (to) $display("[TB] FAIL restart_timeout: got no done expected done"); else passed++;
    for (int k = 0; k < exp_bytes.size(); k++) begin
      total++;
      if (log_base + k >= byte_log.size() || byte_log[log_base + k] !== exp_bytes[k])
        $display("[TB] FAIL restart_byte%0d: got %h expected %h", k,
                 (log_base + k < byte_log.size()) ? byte_log[log_base + k] : 9'h1FF, exp_bytes[k]);
      else passed++;
    end
  endtask

  task automatic test_random;
    bit to;
    int r, nn;
    for (int round = 0; round < 5; round++) begin
      lat_max = int'($urandom_range(3, 0));
      for (int i = 0; i < NUM; i++) begin
        r = int'($urandom_range(11, 0));
        if (r == 7 || r == 8) tbl[i] = {2'b10, 8'($urandom), 16'($urandom_range(3, 0))};
        else if (r == 9) tbl[i] = {2'b11, 24'($urandom)};
        else if (r == 10) tbl[i] = {2'b00, 24'($urandom)};
        else tbl[i] = wr(8'($urandom), 8'($urandom));
      end
      nack_reg = tbl[$urandom_range(NUM - 1, 0)][15:8];
      nn = int'($urandom_range(6, 0));
      nack_limit = nack_used + nn;
      run_model(nn);
      launch();
      wait_done(to);
      total++;
      if (to) $display("[TB] FAIL rand%0d_timeout: got no done expected done", round); else passed++;
      total++;
      if (byte_log.size() - log_base !== exp_bytes.size())
        $display("[TB] FAIL rand%0d_count: got %0d expected %0d", round, byte_log.size() - log_base, exp_bytes.size());
      else passed++;
      for (int k = 0; k < exp_bytes.size() && log_base + k < byte_log.size(); k++) begin
        total++;
        if (byte_log[log_base + k] !== exp_bytes[k])
          $display("[TB] FAIL rand%0d_byte%0d: got %h expected %h", round, k, byte_log[log_base + k], exp_bytes[k]);
        else passed++;
      end
      total++;
      if ({init_error, cur_index, 8'(stop_count - stop_base)} !== {exp_err, ADDR_W'(exp_end), 8'(exp_stops)})
        $display("[TB] FAIL rand%0d_final: got err %b idx %0d stops %0d expected %b %0d %0d", round,
                 init_error, cur_index, stop_count - stop_base, exp_err, exp_end, exp_stops);
      else passed++;
`ifdef I2C_CFG_ERR_CAPTURE_EN
      total++;
      if (err_count !== 8'(exp_err_cnt) || (exp_err_cnt != 0 && err_index !== ADDR_W'(exp_err_idx)))
        $display("[TB] FAIL rand%0d_capture: got %0d/%0d expected %0d/%0d", round,
                 err_index, err_count, exp_err_idx, exp_err_cnt);
      else passed++;
`endif
    end
    nack_reg = 8'hA5;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_writes();
    test_retry_recovers();
    test_retry_exhausted();
    test_delay();
    test_hard_stop();
    test_reset_mid_transfer();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
